immed_gen_pipe: RTL and testbench

- Pipelined, parametrised immediate generator for the decode stage.
- Takes a full 32-bit instruction word plus format select and produces an XLEN-wide immediate through a registered, valid/ready-handshaked output with optional two-entry skid buffering.
- Adds CSR-zimm and shift-amount formats, RV64 sign extension, and an illegal-select flag.
- Carries a sideband tag so downstream stages can match results to instructions.

---
 rtl/immed_gen_pipe.sv | 104 ++++++++++
 tb/tb_immed_gen_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/immed_gen_pipe.sv
// Decode-stage immediate generator: extracts the immediate from a 32-bit instruction word and
// presents it through a valid/ready output register, optionally backed by a one-entry skid slot.
module immed_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned SKID  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ir,
  input  logic [2:0]       imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  localparam logic [2:0] SelI   = 3'b000;
  localparam logic [2:0] SelS   = 3'b001;
  localparam logic [2:0] SelB   = 3'b010;
  localparam logic [2:0] SelU   = 3'b011;
  localparam logic [2:0] SelJ   = 3'b100;
  localparam logic [2:0] SelZ   = 3'b101;
  localparam logic [2:0] SelSh  = 3'b110;
  localparam logic [2:0] SelIll = 3'b111;

  // Stored word layout: {illegal, tag, immediate}
  localparam int unsigned DW = XLEN + TAG_W + 1;

  logic [63:0]   imm64;
  logic [DW-1:0] in_word;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_q, out_d;
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          load_out;
  logic          accept;

  // Build at 64 bits and truncate so the same expressions serve both XLEN values.
  always_comb begin
    imm64 = '0;
    case (imm_sel)
      SelI, SelIll: imm64 = {{52{ir[31]}}, ir[31:20]};
      SelS:         imm64 = {{52{ir[31]}}, ir[31:25], ir[11:7]};
      SelB:         imm64 = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      SelU:         imm64 = {{32{ir[31]}}, ir[31:12], 12'h000};
      SelJ:         imm64 = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      SelZ:         imm64 = {59'd0, ir[19:15]};
      SelSh:        imm64 = (XLEN == 64) ? {58'd0, ir[25:20]} : {59'd0, ir[24:20]};
      default:      imm64 = '0;
    endcase
  end

  assign in_word = {(imm_sel == SelIll), in_tag, imm64[XLEN-1:0]};

  always_comb begin
    load_out     = !out_valid_q || out_ready;
    in_ready     = (SKID != 0) ? !skid_valid_q : load_out;
    accept       = in_valid && in_ready;
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (load_out) begin
      // The skid entry is older than anything at the input, so it drains first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_word;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_word;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign {illegal, out_tag, imm} = out_q;

endmodule

// File: tb/tb_immed_gen_pipe.sv
// Scoreboard bench: one XLEN=32/SKID=1 instance and one XLEN=64/SKID=0 instance, each checked
// against an arithmetic reference model by an independent output monitor.
module tb_immed_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [3:0]  tag;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_ill;
  logic [31:0] a_ir = '0, a_imm;
  logic [2:0]  a_sel = '0;
  logic [3:0]  a_tag = '0, a_out_tag;

  logic        b_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_ill;
  logic [31:0] b_ir = '0;
  logic [63:0] b_imm;
  logic [2:0]  b_sel = '0;
  logic [3:0]  b_tag = '0, b_out_tag;

  immed_gen_pipe #(.XLEN(32), .TAG_W(4), .SKID(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_in_ready), .ir(a_ir),
    .imm_sel(a_sel), .in_tag(a_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .imm(a_imm), .out_tag(a_out_tag), .illegal(a_ill)
  );

  immed_gen_pipe #(.XLEN(64), .TAG_W(4), .SKID(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_in_ready), .ir(b_ir),
    .imm_sel(b_sel), .in_tag(b_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .imm(b_imm), .out_tag(b_out_tag), .illegal(b_ill)
  );

  int   checks = 0;
  int   failures = 0;
  int   a_pops = 0;
  int   a_stalls = 0;
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sext(input longint val, input int width);
    if (val >= (longint'(1) <<< (width - 1))) return val - (longint'(1) <<< width);
    return val;
  endfunction

  // Reference: extract each field as a number, sign/zero-extend arithmetically, then trim to XLEN.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] sel,
                                          input int xlen);
    longint v;
    case (sel)
      3'd1:    v = sext(longint'({w[31:25], w[11:7]}), 12);
      3'd2:    v = sext(longint'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
      3'd3:    v = sext(longint'(w[31:12]) * 4096, 32);
      3'd4:    v = sext(longint'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21);
      3'd5:    v = longint'(w[19:15]);
      3'd6:    v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
      default: v = sext(longint'(w[31:20]), 12);
    endcase
    if (xlen == 32) return {32'h0, v[31:0]};
    return v;
  endfunction

  function automatic exp_t mk(input logic [31:0] w, input logic [2:0] sel, input logic [3:0] tag,
                              input int xlen);
    exp_t e;
    e.imm = ref_imm(w, sel, xlen);
    e.tag = tag;
    e.ill = (sel == 3'd7);
    return e;
  endfunction

  always begin : mon_a
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && a_out_valid && a_out_ready) begin
      a_pops++;
      if (qa.size() == 0) chk("a_unexpected_output", 64'(a_out_tag), 64'hdead);
      else begin
        e = qa.pop_front();
        chk("a_imm", {32'h0, a_imm}, e.imm);
        chk("a_tag", 64'(a_out_tag), 64'(e.tag));
        chk("a_ill", 64'(a_ill), 64'(e.ill));
      end
    end
  end

  always begin : mon_b
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_output", 64'(b_out_tag), 64'hdead);
      else begin
        e = qb.pop_front();
        chk("b_imm", b_imm, e.imm);
        chk("b_tag", 64'(b_out_tag), 64'(e.tag));
        chk("b_ill", 64'(b_ill), 64'(e.ill));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the word was accepted.
  task automatic send_a(input logic [31:0] w, input logic [2:0] sel, input logic [3:0] tag);
    int n = 0;
    a_valid = 1'b1; a_ir = w; a_sel = sel; a_tag = tag;
    #1;
    while (!a_in_ready && n < 50) begin
      @(negedge clk); #1; n++; a_stalls++;
    end
    if (!a_in_ready) chk("a_accept_timeout", 64'(n), 64'd0);
    else qa.push_back(mk(w, sel, tag, 32));
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] w, input logic [2:0] sel, input logic [3:0] tag);
    int n = 0;
    b_valid = 1'b1; b_ir = w; b_sel = sel; b_tag = tag;
    #1;
    while (!b_in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!b_in_ready) chk("b_accept_timeout", 64'(n), 64'd0);
    else qb.push_back(mk(w, sel, tag, 64));
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic rand_a(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      a_out_ready = ($urandom % 4) != 0;
      a_valid = 1'($urandom);
      a_ir = $urandom;
      a_sel = 3'($urandom);
      a_tag = 4'($urandom);
      #1;
      if (a_valid && a_in_ready) qa.push_back(mk(a_ir, a_sel, a_tag, 32));
    end
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic rand_b(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      b_out_ready = ($urandom % 3) != 0;
      b_valid = 1'($urandom);
      b_ir = $urandom;
      b_sel = 3'($urandom);
      b_tag = 4'($urandom);
      #1;
      if (b_valid && b_in_ready) qb.push_back(mk(b_ir, b_sel, b_tag, 64));
    end
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] w;
    logic [2:0]  sel;
    logic [63:0] imm;
  } vec_t;

  initial begin
    vec_t va[5];
    vec_t vb[3];
    int   pops0, stalls0;
    va[0] = '{32'hFFF00093, 3'd0, 64'hFFFFFFFF};
    va[1] = '{32'hFE000EE3, 3'd2, 64'hFFFFFFFC};
    va[2] = '{32'h123450B7, 3'd3, 64'h12345000};
    va[3] = '{32'h0010006F, 3'd4, 64'h00000800};
    va[4] = '{32'h000F9073, 3'd5, 64'h0000001F};
    vb[0] = '{32'h800000B7, 3'd3, 64'hFFFFFFFF80000000};
    vb[1] = '{32'h03F01093, 3'd6, 64'h000000000000003F};
    vb[2] = '{32'h00100093, 3'd7, 64'h0000000000000001};

    repeat (2) @(negedge clk);
    chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_imm", 64'(a_imm), 64'd0);
    chk("rst_a_out_tag", 64'(a_out_tag), 64'd0);
    chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    rst_n = 1'b1;

    // Directed formats with one-cycle latency.
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_a(va[i].w, va[i].sel, 4'(i + 1));
      #2;
      chk("a_lat_valid", 64'(a_out_valid), 64'd1);
      chk("a_fmt_imm", {32'h0, a_imm}, va[i].imm);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      send_b(vb[i].w, vb[i].sel, 4'(i + 1));
      #2;
      chk("b_fmt_imm", b_imm, vb[i].imm);
      chk("b_fmt_ill", 64'(b_ill), (i == 2) ? 64'd1 : 64'd0);
      @(negedge clk);
    end

    // Backpressure into the skid slot.
    a_out_ready = 1'b0;
    fork
      for (int t = 1; t <= 5; t++) send_a(32'h00000013 | (32'(t) << 20), 3'd0, 4'(t));
    join_none
    repeat (4) @(negedge clk);
    #3;
    chk("bp_in_ready_low", 64'(a_in_ready), 64'd0);
    chk("bp_out_tag_held", 64'(a_out_tag), 64'd1);
    chk("bp_tag3_waiting", 64'(a_tag), 64'd3);
    @(negedge clk);
    pops0 = a_pops;
    a_out_ready = 1'b1;
    repeat (5) @(negedge clk);
    #3;
    chk("bp_no_gaps", 64'(a_pops - pops0), 64'd5);
    wait fork;

    // Sustained throughput.
    @(negedge clk);
    pops0 = a_pops;
    stalls0 = a_stalls;
    for (int i = 0; i < 16; i++) send_a($urandom, 3'($urandom_range(0, 6)), 4'(i));
    #3;
    chk("tp_in_ready_never_low", 64'(a_stalls - stalls0), 64'd0);
    chk("tp_outputs_continuous", 64'(a_pops - pops0), 64'd16);

    // Combinational ready without a skid slot.
    @(negedge clk);
    b_out_ready = 1'b0;
    send_b(32'h00500093, 3'd0, 4'hA);
    b_valid = 1'b1; b_ir = 32'h00600093; b_sel = 3'd0; b_tag = 4'hB;
    #1;
    chk("s0_stall_in_ready", 64'(b_in_ready), 64'd0);
    b_out_ready = 1'b1;
    #1;
    chk("s0_drain_in_ready", 64'(b_in_ready), 64'd1);
    qb.push_back(mk(32'h00600093, 3'd0, 4'hB, 64));
    @(negedge clk);
    b_valid = 1'b0;
    #2;
    chk("s0_replaced_tag", 64'(b_out_tag), 64'hB);
    @(negedge clk);

    // Asynchronous reset with output and skid occupied.
    a_out_ready = 1'b0;
    send_a(32'h00700093, 3'd0, 4'd7);
    send_a(32'h00800093, 3'd0, 4'd8);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("mid_rst_imm", 64'(a_imm), 64'd0);
    chk("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
    qa.delete();
    qb.delete();
    rst_n = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b1;
    send_a(32'h00900093, 3'd0, 4'd9);
    #2;
    chk("post_rst_tag9", 64'(a_out_tag), 64'd9);
    @(negedge clk);

    rand_a(400);
    rand_b(400);

    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    chk("drain_a_empty", 64'(qa.size()), 64'd0);
    chk("drain_b_empty", 64'(qb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
